// File: rtl/md5hf_axil_pkg.sv
// md5hf_axil_pkg: shared types and helpers for the MD5HF AXI4-Lite register slave.
//   resp_t      AXI response codes used on BRESP/RRESP.
//   wr_state_t  write-channel FSM states.
//   byte_merge  byte-enable merge of new write data into an existing word.
package md5hf_axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WAIT,
      WR_RESP
   } wr_state_t;

   // Byte b of the result comes from new_w when strb[b] is set, else from old_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/md5hf_axil_slave_regs.sv
// md5hf_axil_slave_regs: AXI4-Lite slave on the MD5HF S00_AXI port.
//   Holds NUM_REGS 32-bit RW registers (word index = addr[ADDR_WIDTH-1:2]),
//   exposes them on reg_q and pulses reg_wr_pulse[i] for one cycle on every
//   in-range write commit. Out-of-range accesses answer SLVERR.
// Ports:
//   S00_AXI_ACLK / S00_AXI_ARESET  clock, synchronous active-high reset
//   S00_AXI_AW* / W* / B*          write address, data and response channels
//   S00_AXI_AR* / R*               read address and data channels
//   reg_q                          register contents, reg i at [32i+31:32i]
//   reg_wr_pulse                   per-register commit pulse
module md5hf_axil_slave_regs
   import md5hf_axil_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 5,
   parameter int          NUM_REGS   = 4,
   parameter logic [31:0] RESET_VAL  = 32'h0
) (
   input  logic                     S00_AXI_ACLK,
   input  logic                     S00_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]    S00_AXI_AWADDR,
   input  logic [2:0]               S00_AXI_AWPROT,
   input  logic                     S00_AXI_AWVALID,
   output logic                     S00_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]    S00_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]  S00_AXI_WSTRB,
   input  logic                     S00_AXI_WVALID,
   output logic                     S00_AXI_WREADY,
   output logic [1:0]               S00_AXI_BRESP,
   output logic                     S00_AXI_BVALID,
   input  logic                     S00_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]    S00_AXI_ARADDR,
   input  logic [2:0]               S00_AXI_ARPROT,
   input  logic                     S00_AXI_ARVALID,
   output logic                     S00_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]    S00_AXI_RDATA,
   output logic [1:0]               S00_AXI_RRESP,
   output logic                     S00_AXI_RVALID,
   input  logic                     S00_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   logic                          clk, rst;
   logic                          live;     // 0 during reset so every READY reads 0
   logic [NUM_REGS-1:0][31:0]     regs;

   wr_state_t                     wr_state, wr_next;
   logic                          aw_held;  // in WR_WAIT: 1 = AW latched, 0 = W latched
   logic [ADDR_WIDTH-1:0]         aw_lat;
   logic [DATA_WIDTH-1:0]         w_lat;
   logic [DATA_WIDTH/8-1:0]       wstrb_lat;
   logic [1:0]                    bresp_q;

   logic                          awready, wready, bvalid, commit;
   logic                          aw_hs, w_hs;
   logic [ADDR_WIDTH-1:0]         wr_addr;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [DATA_WIDTH/8-1:0]       wr_strb;
   logic [IDX_W-1:0]              wr_idx, rd_idx;
   logic                          wr_in_range, rd_in_range;

   logic                          rvalid_q, ar_hs;
   logic [DATA_WIDTH-1:0]         rdata_q, rd_word;
   logic [1:0]                    rresp_q;

   assign clk = S00_AXI_ACLK;
   assign rst = S00_AXI_ARESET;

   // PROT and the byte offset carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{S00_AXI_AWPROT, S00_AXI_ARPROT,
                        S00_AXI_AWADDR[1:0], S00_AXI_ARADDR[1:0]};

   always_ff @(posedge clk) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   // ---------------- write FSM ----------------
   assign aw_hs = S00_AXI_AWVALID & awready;
   assign w_hs  = S00_AXI_WVALID  & wready;

   always_comb begin
      wr_next = wr_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      commit  = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            awready = live;
            wready  = live;
            if (S00_AXI_AWVALID && S00_AXI_WVALID && live) begin
               commit  = 1'b1;
               wr_next = WR_RESP;
            end else if ((S00_AXI_AWVALID || S00_AXI_WVALID) && live) begin
               wr_next = WR_WAIT;
            end
         end
         WR_WAIT: begin
            awready = ~aw_held;
            wready  = aw_held;
            if (aw_held ? S00_AXI_WVALID : S00_AXI_AWVALID) begin
               commit  = 1'b1;
               wr_next = WR_RESP;
            end
         end
         WR_RESP: begin
            bvalid = 1'b1;
            if (S00_AXI_BREADY) wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) wr_state <= WR_IDLE;
      else     wr_state <= wr_next;
   end

   // The later handshake takes its half from the live bus, the other from the latch.
   assign wr_addr     = aw_hs ? S00_AXI_AWADDR : aw_lat;
   assign wr_data     = w_hs  ? S00_AXI_WDATA  : w_lat;
   assign wr_strb     = w_hs  ? S00_AXI_WSTRB  : wstrb_lat;
   assign wr_idx      = wr_addr[ADDR_WIDTH-1:2];
   assign wr_in_range = 32'(wr_idx) < NUM_REGS;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held      <= 1'b0;
         aw_lat       <= '0;
         w_lat        <= '0;
         wstrb_lat    <= '0;
         bresp_q      <= RESP_OKAY;
         reg_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else begin
         reg_wr_pulse <= '0;
         if (wr_state == WR_IDLE && aw_hs && !w_hs) begin
            aw_lat  <= S00_AXI_AWADDR;
            aw_held <= 1'b1;
         end
         if (wr_state == WR_IDLE && w_hs && !aw_hs) begin
            w_lat     <= S00_AXI_WDATA;
            wstrb_lat <= S00_AXI_WSTRB;
            aw_held   <= 1'b0;
         end
         if (commit) begin
            bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_in_range && wr_idx == IDX_W'(i)) begin
                  regs[i]         <= byte_merge(regs[i], wr_data, wr_strb);
                  reg_wr_pulse[i] <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- read path ----------------
   assign ar_hs       = S00_AXI_ARVALID & S00_AXI_ARREADY;
   assign rd_idx      = S00_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign rd_in_range = 32'(rd_idx) < NUM_REGS;

   // Out-of-range indices match no register and read as zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) rd_word = regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_word;   // sampled before any same-edge write lands
         rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S00_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign S00_AXI_AWREADY = awready;
   assign S00_AXI_WREADY  = wready;
   assign S00_AXI_BVALID  = bvalid;
   assign S00_AXI_BRESP   = bresp_q;
   assign S00_AXI_ARREADY = live & ~rvalid_q;
   assign S00_AXI_RVALID  = rvalid_q;
   assign S00_AXI_RDATA   = rdata_q;
   assign S00_AXI_RRESP   = rresp_q;
   assign reg_q           = regs;

endmodule

// File: tb/tb_md5hf_axil_slave_regs.sv
// Directed bench for md5hf_axil_slave_regs: inputs driven and outputs sampled
// on the falling edge, expected values hand-computed.
module tb_md5hf_axil_slave_regs;

   logic         clk, arst;
   logic [4:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [127:0] reg_q;
   logic [3:0]   reg_wr_pulse;

   int errors = 0;
   int checks = 0;
   int pulse_cnt [4] = '{0, 0, 0, 0};

   md5hf_axil_slave_regs dut (
      .S00_AXI_ACLK(clk),        .S00_AXI_ARESET(arst),
      .S00_AXI_AWADDR(awaddr),   .S00_AXI_AWPROT(awprot),
      .S00_AXI_AWVALID(awvalid), .S00_AXI_AWREADY(awready),
      .S00_AXI_WDATA(wdata),     .S00_AXI_WSTRB(wstrb),
      .S00_AXI_WVALID(wvalid),   .S00_AXI_WREADY(wready),
      .S00_AXI_BRESP(bresp),     .S00_AXI_BVALID(bvalid),
      .S00_AXI_BREADY(bready),
      .S00_AXI_ARADDR(araddr),   .S00_AXI_ARPROT(arprot),
      .S00_AXI_ARVALID(arvalid), .S00_AXI_ARREADY(arready),
      .S00_AXI_RDATA(rdata),     .S00_AXI_RRESP(rresp),
      .S00_AXI_RVALID(rvalid),   .S00_AXI_RREADY(rready),
      .reg_q(reg_q),             .reg_wr_pulse(reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each pulse is high across exactly one rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [1:0] resp);
      bit aw_now, w_now, done;
      done = 1'b0;
      resp = 2'bxx;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         tick();
         if (aw_now) awvalid = 1'b0;
         if (w_now)  wvalid  = 1'b0;
         if (bvalid) begin resp = bresp; done = 1'b1; end
      end
      tick();
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $error("FAIL wr_timeout: observed no BVALID expected BVALID within 20 cycles");
      end
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit ar_now, done;
      done = 1'b0;
      d = 'x; resp = 2'bxx;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         ar_now = arvalid && arready;
         tick();
         if (ar_now) arvalid = 1'b0;
         if (rvalid) begin d = rdata; resp = rresp; done = 1'b1; end
      end
      tick();
      rready = 1'b0; arvalid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $error("FAIL rd_timeout: observed no RVALID expected RVALID within 20 cycles");
      end
   endtask

   initial begin
      logic [1:0]   r;
      logic [31:0]  d;
      logic [127:0] snap_q;
      int           snap_p;

      arst = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = '0; wstrb = '0;

      // reset state
      repeat (2) tick();
      chk("rst_hs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
      chk("rst_data", {bresp, rresp, rdata, reg_wr_pulse}, 40'h0);
      chk("rst_regs", reg_q, 128'h0);
      arst = 1'b0;
      tick();
      chk("post_rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);

      // T1 sequential write/read
      for (int i = 0; i < 4; i++) begin
         wr(5'(4 * i), 32'(i + 1), 4'hF, r);
         chk("t1_bresp", r, 2'b00);
      end
      chk("t1_regs", reg_q, {32'd4, 32'd3, 32'd2, 32'd1});
      for (int i = 0; i < 4; i++) begin
         rd(5'(4 * i), d, r);
         chk("t1_rdata", {r, d}, {2'b00, 32'(i + 1)});
         chk("t1_pulses", pulse_cnt[i], 1);
      end

      // T2a: W first, AW three cycles later (reg1)
      wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("t2a_wait_ready", {awready, wready, bvalid}, 3'b100);
      repeat (2) tick();
      chk("t2a_no_early_commit", {bvalid, reg_q[63:32]}, {1'b0, 32'd2});
      awaddr = 5'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t2a_commit", {bvalid, bresp, reg_wr_pulse, reg_q[63:32]},
          {1'b1, 2'b00, 4'b0010, 32'hCAFE0001});
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("t2a_b_done", {bvalid, reg_wr_pulse, awready, wready}, 7'b0000011);

      // T2b: AW first, W three cycles later (reg2)
      awaddr = 5'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t2b_wait_ready", {awready, wready, bvalid}, 3'b010);
      repeat (2) tick();
      wdata = 32'hBEEF0002; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("t2b_commit", {bvalid, bresp, reg_wr_pulse, reg_q[95:64]},
          {1'b1, 2'b00, 4'b0100, 32'hBEEF0002});
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("t2b_b_done", bvalid, 1'b0);

      // T3 strobes
      wr(5'h00, 32'h11223344, 4'hF, r);
      wr(5'h00, 32'hAABBCCDD, 4'b0101, r);
      chk("t3_merge", reg_q[31:0], 32'h11BB33DD);
      rd(5'h00, d, r);
      chk("t3_rd", {r, d}, {2'b00, 32'h11BB33DD});
      snap_p = pulse_cnt[2];
      wr(5'h08, 32'hFFFFFFFF, 4'h0, r);
      chk("t3_strb0", {r, reg_q[95:64]}, {2'b00, 32'hBEEF0002});
      chk("t3_strb0_pulse", pulse_cnt[2], snap_p + 1);

      // T4 out of range, and unaligned aliasing
      snap_q = reg_q;
      snap_p = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      wr(5'h10, 32'hDEADBEEF, 4'hF, r);
      chk("t4_bresp", r, 2'b10);
      chk("t4_regs", reg_q, snap_q);
      chk("t4_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], snap_p);
      rd(5'h1C, d, r);
      chk("t4_rd", {r, d}, {2'b10, 32'h0});
      rd(5'h06, d, r);
      chk("t4_unaligned", {r, d}, {2'b00, 32'hCAFE0001});

      // T5 same-edge read/write of reg3, then back-pressure on both channels
      snap_p = pulse_cnt[3];
      awaddr = 5'h0C; wdata = 32'h33333333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h0E; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("t5_rd_old", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'd4});
      chk("t5_wr_new", {bvalid, reg_q[127:96]}, {1'b1, 32'h33333333});
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_hold", {bvalid, awready, wready, rvalid, arready, bresp, rresp, rdata},
             {5'b10010, 2'b00, 2'b00, 32'd4});
      end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      chk("t5_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
      repeat (2) tick();
      chk("t5_no_dup", {bvalid, rvalid}, 2'b00);
      chk("t5_pulse_once", pulse_cnt[3], snap_p + 1);

      // T6a reset with B and R responses pending
      awaddr = 5'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h04; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("t6_pending", {bvalid, rvalid}, 2'b11);
      arst = 1'b1;
      tick();
      chk("t6_in_rst", {awready, wready, bvalid, arready, rvalid, reg_wr_pulse}, 9'b0);
      chk("t6_regs", reg_q, 128'h0);
      arst = 1'b0; bready = 1'b1; rready = 1'b1;
      tick();
      chk("t6_after_rst", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
      repeat (3) tick();
      chk("t6_no_stale", {bvalid, rvalid}, 2'b00);
      bready = 1'b0; rready = 1'b0;

      // T6b reset while the AW latch is held: a later lone W must not commit
      awaddr = 5'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t6b_aw_held", {awready, wready}, 2'b01);
      arst = 1'b1;
      tick();
      arst = 1'b0;
      tick();
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("t6b_no_commit", {bvalid, awready, wready, reg_q}, {3'b010, 128'h0});
      awaddr = 5'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t6b_commit", {bvalid, bresp, reg_q[63:32]}, {1'b1, 2'b00, 32'h77});
      bready = 1'b1;
      tick();
      bready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
